// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32imc_types (package)
// Brief    : Shared widths, arbiter state encoding and request record for the
//            unified memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rv32imc_types;

    localparam int C_ADDR_W = 32;
    localparam int C_DATA_W = 32;
    localparam int C_MASK_W = C_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [C_ADDR_W-1:0] addr;
        logic [C_MASK_W-1:0] rmask;
        logic [C_MASK_W-1:0] wmask;
        logic [C_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic req_active(input mem_req_t r);
        return |{r.rmask, r.wmask};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, data and downstream mask-pulse buses of the memory port
//            arbiter; slave = arbiter view, master = requester/memory view.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = rv32imc_types::C_ADDR_W,
    parameter int DATA_W = rv32imc_types::C_DATA_W
);
    logic [ADDR_W-1:0]   imem_addr;
    logic [DATA_W/8-1:0] imem_rmask;
    logic [DATA_W-1:0]   imem_rdata;
    logic                imem_resp;

    logic [ADDR_W-1:0]   dmem_addr;
    logic [DATA_W/8-1:0] dmem_rmask;
    logic [DATA_W/8-1:0] dmem_wmask;
    logic [DATA_W-1:0]   dmem_wdata;
    logic [DATA_W-1:0]   dmem_rdata;
    logic                dmem_resp;

    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W/8-1:0] mem_rmask;
    logic [DATA_W/8-1:0] mem_wmask;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_resp;

    modport slave (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_req_buffer.sv
`default_nettype none
// ============================================================================
// Module   : arb_req_buffer
// Brief    : One-entry hold register for a request that lost arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module arb_req_buffer
    import rv32imc_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load_i,
    input  logic     clear_i,
    input  mem_req_t req_i,
    output logic     valid_o,
    output mem_req_t req_o
);

    logic     valid_q;
    mem_req_t req_q;

    // Clear wins: a granted entry must never survive into the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            req_q   <= req_i;
        end
    end

    assign valid_o = valid_q;
    assign req_o   = req_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one mask-pulse memory port between fetch and data ports.
//            Optional macro ARB_ROUND_ROBIN_EN: alternate winner on contention.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import rv32imc_types::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
)
(
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    if (ADDR_W != C_ADDR_W || DATA_W != C_DATA_W) begin : g_width_check
        $error("mem_port_arbiter: widths must match rv32imc_types");
    end

    arb_state_t        state_q, state_d;
    mem_req_t          i_live, d_live, i_pend, d_pend, i_cand, d_cand, grant_req;
    logic              i_pend_vld, d_pend_vld, i_has, d_has;
    logic              grant_i, grant_d, i_resp, d_resp, d_wins_tie;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

    assign i_live = '{addr: bus.imem_addr, rmask: bus.imem_rmask, wmask: '0, wdata: '0};
    assign d_live = '{addr: bus.dmem_addr, rmask: bus.dmem_rmask,
                      wmask: bus.dmem_wmask, wdata: bus.dmem_wdata};

    // A buffered request always outranks the live inputs of the same port.
    assign i_cand = i_pend_vld ? i_pend : i_live;
    assign d_cand = d_pend_vld ? d_pend : d_live;
    assign i_has  = i_pend_vld | req_active(i_live);
    assign d_has  = d_pend_vld | req_active(d_live);

    arb_req_buffer u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (req_active(i_live) & ~grant_i),
        .clear_i (grant_i),
        .req_i   (i_live),
        .valid_o (i_pend_vld),
        .req_o   (i_pend)
    );

    arb_req_buffer u_dbuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (req_active(d_live) & ~grant_d),
        .clear_i (grant_d),
        .req_i   (d_live),
        .valid_o (d_pend_vld),
        .req_o   (d_pend)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;

    // Tracks only contended grants; uncontended ones do not shift fairness.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else if ((grant_i | grant_d) && i_has && d_has) begin
            last_d_q <= grant_d;
        end
    end

    assign d_wins_tie = ~last_d_q;
`else
    assign d_wins_tie = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (d_has && (!i_has || d_wins_tie)) begin
                        grant_d = 1'b1;
                        state_d = BUSY_D;
                    end else if (i_has) begin
                        grant_i = 1'b1;
                        state_d = BUSY_I;
                    end
                end
            end
            BUSY_I: begin
                if (bus.mem_resp && !rst) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            BUSY_D: begin
                if (bus.mem_resp && !rst) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_req = grant_d ? d_cand : (grant_i ? i_cand : '0);

    assign bus.mem_addr   = grant_req.addr;
    assign bus.mem_rmask  = grant_req.rmask;
    assign bus.mem_wmask  = grant_req.wmask;
    assign bus.mem_wdata  = grant_req.wdata;

    assign bus.imem_resp  = i_resp;
    assign bus.dmem_resp  = d_resp;
    assign bus.imem_rdata = i_resp ? bus.mem_rdata : i_rdata_q;
    assign bus.dmem_rdata = d_resp ? bus.mem_rdata : d_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (i_resp) i_rdata_q <= bus.mem_rdata;
            if (d_resp) d_rdata_q <= bus.mem_rdata;
        end
    end

    a_imem_one_outstanding: assert property (@(posedge clk) disable iff (rst)
        req_active(i_live) |-> !(i_pend_vld || state_q == BUSY_I));
    a_dmem_one_outstanding: assert property (@(posedge clk) disable iff (rst)
        req_active(d_live) |-> !(d_pend_vld || state_q == BUSY_D));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed and random bench for mem_port_arbiter with a
//            transaction-level arbitration and memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Requester/arbiter model state
    bit          i_out, d_out, busy, owner_d, last_tie_d;
    req_t        wait_i[$];
    req_t        wait_d[$];
    logic [31:0] exp_i_rdata, exp_d_rdata;

    // Downstream memory model
    logic [31:0] mem_model [logic [31:0]];
    bit          rsp_pending;
    int          rsp_cnt;
    int          lat_cfg = 1;
    bit          lat_rand;
    logic [31:0] op_addr, op_wdata, rsp_val;
    logic [3:0]  op_wmask;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit   was_busy, pick_d;
        req_t g;
        if (rst) begin
            chk("rst_rmask", 32'(bus.mem_rmask), 0);
            chk("rst_wmask", 32'(bus.mem_wmask), 0);
            chk("rst_iresp", 32'(bus.imem_resp), 0);
            chk("rst_dresp", 32'(bus.dmem_resp), 0);
            wait_i.delete();
            wait_d.delete();
            busy = 0; i_out = 0; d_out = 0; last_tie_d = 0;
            exp_i_rdata = '0; exp_d_rdata = '0;
            return;
        end
        if (bus.imem_rmask != 0)
            wait_i.push_back('{addr: bus.imem_addr, rmask: bus.imem_rmask, wmask: 4'h0, wdata: 32'h0});
        if (bus.dmem_rmask != 0 || bus.dmem_wmask != 0)
            wait_d.push_back('{addr: bus.dmem_addr, rmask: bus.dmem_rmask,
                               wmask: bus.dmem_wmask, wdata: bus.dmem_wdata});
        was_busy = busy;
        if (bus.mem_resp && busy) begin
            chk("resp_i_owner", 32'(bus.imem_resp), 32'(!owner_d));
            chk("resp_d_owner", 32'(bus.dmem_resp), 32'(owner_d));
            if (owner_d) begin
                chk("d_rdata_route", bus.dmem_rdata, rsp_val);
                chk("i_rdata_hold", bus.imem_rdata, exp_i_rdata);
                exp_d_rdata = rsp_val;
                d_out = 0;
            end else begin
                chk("i_rdata_route", bus.imem_rdata, rsp_val);
                chk("d_rdata_hold", bus.dmem_rdata, exp_d_rdata);
                exp_i_rdata = rsp_val;
                i_out = 0;
            end
            busy = 0;
        end else begin
            chk("no_iresp", 32'(bus.imem_resp), 0);
            chk("no_dresp", 32'(bus.dmem_resp), 0);
            chk("i_rdata_hold", bus.imem_rdata, exp_i_rdata);
            chk("d_rdata_hold", bus.dmem_rdata, exp_d_rdata);
        end
        if (!was_busy && (wait_i.size() > 0 || wait_d.size() > 0)) begin
            if (wait_i.size() > 0 && wait_d.size() > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                pick_d     = !last_tie_d;
                last_tie_d = pick_d;
`else
                pick_d = 1'b1;
`endif
            end else begin
                pick_d = (wait_d.size() > 0);
            end
            g       = pick_d ? wait_d.pop_front() : wait_i.pop_front();
            busy    = 1;
            owner_d = pick_d;
            chk("grant_addr", bus.mem_addr, g.addr);
            chk("grant_rmask", 32'(bus.mem_rmask), 32'(g.rmask));
            chk("grant_wmask", 32'(bus.mem_wmask), 32'(g.wmask));
            if (g.wmask != 0) chk("grant_wdata", bus.mem_wdata, g.wdata);
        end else begin
            chk("quiet_rmask", 32'(bus.mem_rmask), 0);
            chk("quiet_wmask", 32'(bus.mem_wmask), 0);
        end
        if (bus.mem_rmask != 0 || bus.mem_wmask != 0) begin
            rsp_pending = 1;
            rsp_cnt     = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
            op_addr     = bus.mem_addr;
            op_wmask    = bus.mem_wmask;
            op_wdata    = bus.mem_wdata;
        end
    endtask

    task automatic responder_adv();
        logic [31:0] v;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = $urandom();
        if (rsp_pending) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                rsp_val       = mem_rd(op_addr);
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = rsp_val;
                if (op_wmask != 0) begin
                    v = rsp_val;
                    for (int b = 0; b < 4; b++)
                        if (op_wmask[b]) v[8*b +: 8] = op_wdata[8*b +: 8];
                    mem_model[op_addr] = v;
                end
                rsp_pending = 0;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        cycle++;
        bus.imem_rmask = '0;
        bus.dmem_rmask = '0;
        bus.dmem_wmask = '0;
        bus.imem_addr  = $urandom();
        bus.dmem_addr  = $urandom();
        bus.dmem_wdata = $urandom();
        responder_adv();
    endtask

    task automatic drive_i(input logic [31:0] a);
        bus.imem_addr  = a;
        bus.imem_rmask = 4'hF;
        i_out = 1;
    endtask

    task automatic drive_d(input logic [31:0] a, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] wd);
        bus.dmem_addr  = a;
        bus.dmem_rmask = rm;
        bus.dmem_wmask = wm;
        bus.dmem_wdata = wd;
        d_out = 1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((i_out || d_out || busy || rsp_pending) && n < 300) begin
            cyc();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 300), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        bus.imem_addr = '0; bus.imem_rmask = '0;
        bus.dmem_addr = '0; bus.dmem_rmask = '0; bus.dmem_wmask = '0; bus.dmem_wdata = '0;
        bus.mem_rdata = '0; bus.mem_resp = 1'b0;
        mem_model[32'h0000_1000] = 32'hDEAD_BEEF;
        mem_model[32'h0000_0010] = 32'h1111_1111;
        mem_model[32'h0000_0014] = 32'h2222_2222;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        chk("rst_state_rmask", 32'(bus.mem_rmask), 0);
        chk("rst_state_wmask", 32'(bus.mem_wmask), 0);
        chk("rst_state_addr", bus.mem_addr, 0);
        chk("rst_state_iresp", 32'(bus.imem_resp), 0);
        chk("rst_state_irdata", bus.imem_rdata, 0);
        chk("rst_state_drdata", bus.dmem_rdata, 0);

        // Single imem read, 3-cycle downstream latency
        lat_cfg = 3;
        drive_i(32'h0000_1000);
        #1;
        chk("t1_req_rmask", 32'(bus.mem_rmask), 32'hF);
        chk("t1_req_addr", bus.mem_addr, 32'h0000_1000);
        cyc(); cyc(); cyc();
        #1;
        chk("t1_resp", 32'(bus.imem_resp), 1);
        chk("t1_rdata", bus.imem_rdata, 32'hDEAD_BEEF);
        drain("t1");
        chk("t1_rdata_hold", bus.imem_rdata, 32'hDEAD_BEEF);

        // Simultaneous imem read and dmem write
        lat_cfg = 2;
        drive_i(32'h0000_0100);
        drive_d(32'h0000_0200, 4'h0, 4'h3, 32'h0000_1234);
        #1;
        chk("t2_first_addr", bus.mem_addr, 32'h0000_0200);
        chk("t2_first_wmask", 32'(bus.mem_wmask), 32'h3);
        chk("t2_first_rmask", 32'(bus.mem_rmask), 0);
        cyc(); cyc(); cyc();
        #1;
        chk("t2_second_addr", bus.mem_addr, 32'h0000_0100);
        chk("t2_second_rmask", 32'(bus.mem_rmask), 32'hF);
        drain("t2");

        // Two consecutive contended pairs from a fresh reset
        do_reset();
        lat_cfg = 1;
        drive_i(32'h0000_0400);
        drive_d(32'h0000_0500, 4'hF, 4'h0, 32'h0);
        #1;
        chk("t3_a_first", bus.mem_addr, 32'h0000_0500);
        cyc(); cyc();
        #1;
        chk("t3_a_second", bus.mem_addr, 32'h0000_0400);
        drain("t3a");
        drive_i(32'h0000_0410);
        drive_d(32'h0000_0510, 4'hF, 4'h0, 32'h0);
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        chk("t3_b_first", bus.mem_addr, 32'h0000_0410);
`else
        chk("t3_b_first", bus.mem_addr, 32'h0000_0510);
`endif
        cyc(); cyc();
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        chk("t3_b_second", bus.mem_addr, 32'h0000_0510);
`else
        chk("t3_b_second", bus.mem_addr, 32'h0000_0410);
`endif
        drain("t3b");

        // dmem write arriving while an imem transaction is open
        lat_cfg = 3;
        drive_i(32'h0000_0300);
        cyc();
        drive_d(32'h0000_0308, 4'h0, 4'hF, 32'hCAFE_F00D);
        #1;
        chk("t4_busy_wmask", 32'(bus.mem_wmask), 0);
        cyc(); cyc(); cyc();
        #1;
        chk("t4_issue_wmask", 32'(bus.mem_wmask), 32'hF);
        chk("t4_issue_addr", bus.mem_addr, 32'h0000_0308);
        chk("t4_issue_wdata", bus.mem_wdata, 32'hCAFE_F00D);
        cyc();
        #1;
        chk("t4_pulse_end", 32'(bus.mem_wmask), 0);
        drain("t4");

        // Reset while a dmem transaction is open; stale response afterwards
        lat_cfg = 3;
        drive_d(32'h0000_0308, 4'hF, 4'h0, 32'h0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        #1;
        chk("t5_stale_seen", 32'(bus.mem_resp), 1);
        chk("t5_stale_dresp", 32'(bus.dmem_resp), 0);
        chk("t5_stale_iresp", 32'(bus.imem_resp), 0);
        cyc();
        drive_i(32'h0000_1000);
        #1;
        chk("t5_grant_now", 32'(bus.mem_rmask), 32'hF);
        drain("t5");

        // Back-to-back dmem reads, 1-cycle latency
        lat_cfg = 1;
        drive_d(32'h0000_0010, 4'hF, 4'h0, 32'h0);
        cyc(); cyc();
        #1;
        chk("t6_first_data", bus.dmem_rdata, 32'h1111_1111);
        drive_d(32'h0000_0014, 4'hF, 4'h0, 32'h0);
        #1;
        chk("t6_second_issue", bus.mem_addr, 32'h0000_0014);
        cyc(); cyc();
        #1;
        chk("t6_second_data", bus.dmem_rdata, 32'h2222_2222);
        drain("t6");

        // Random traffic against the reference model
        lat_rand = 1;
        for (int n = 0; n < 600; n++) begin
            if (!i_out && $urandom_range(0, 2) == 0)
                drive_i(32'h40 + 4 * $urandom_range(0, 7));
            if (!d_out && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    drive_d(32'h40 + 4 * $urandom_range(0, 7), 4'($urandom_range(1, 15)), 4'h0, 32'h0);
                else
                    drive_d(32'h40 + 4 * $urandom_range(0, 7), 4'h0, 4'($urandom_range(1, 15)), $urandom());
            end
            cyc();
        end
        drain("rand");
        lat_rand = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (imem) and the data-memory requester (dmem).
- Uses the codebase's mask-pulse protocol:
  - A request is a single cycle with a nonzero rmask or wmask.
  - Completion is a single-cycle resp.
- Sits between the fetch/WB pipeline stages and the cache/memory subsystem.
- Serialises requests, buffers a losing request, and routes each response back to its owner.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; mask width = DATA_W/8

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
imem_addr  input  ADDR_W  fetch request address
imem_rmask  input  DATA_W/8  fetch read mask; nonzero = request this cycle
imem_rdata  output  DATA_W  fetch read data, valid with imem_resp
imem_resp  output  1  fetch completion pulse
dmem_addr  input  ADDR_W  data request address
dmem_rmask  input  DATA_W/8  data read mask
dmem_wmask  input  DATA_W/8  data write mask
dmem_wdata  input  DATA_W  data write data
dmem_rdata  output  DATA_W  data read data, valid with dmem_resp
dmem_resp  output  1  data completion pulse
mem_addr  output  ADDR_W  downstream address
mem_rmask  output  DATA_W/8  downstream read mask (one-cycle pulse)
mem_wmask  output  DATA_W/8  downstream write mask (one-cycle pulse)
mem_wdata  output  DATA_W  downstream write data
mem_rdata  input  DATA_W  downstream read data
mem_resp  input  1  downstream completion pulse

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values:
  - state = IDLE; both pending entries invalid; owner cleared.
  - mem_rmask = mem_wmask = 0; imem_resp = dmem_resp = 0.
  - Data outputs = 0.
- Requester protocol: each requester has at most one outstanding request and issues no new request before its resp. Violations are flagged by a simulation assertion only.
- Pending buffers, one entry per requester:
  - A request that arrives and is not granted that cycle is captured (addr, masks, wdata).
  - The entry is cleared in the cycle it is granted.
- States:
  - IDLE: no downstream transaction open.
  - BUSY_I: an imem transaction is open.
  - BUSY_D: a dmem transaction is open.
- Grant in IDLE:
  - Candidates: per requester, its pending entry, otherwise its live input.
  - Granted request is driven on mem_* combinationally in the same cycle (zero-cycle latency when IDLE).
  - Next state is BUSY_I or BUSY_D.
  - One grant per cycle.
- Priority with both candidates present: dmem wins (fixed priority); imem is held in its pending buffer.
- BUSY_x:
  - mem_rmask and mem_wmask are 0 (pulse already sent).
  - Live requests arriving now are captured into pending.
  - On mem_resp: mem_rdata is routed to the owner's rdata, owner's resp = 1 in the same cycle, non-owner resp = 0; next state is IDLE.
- No new grant is issued in the mem_resp cycle; the earliest next grant is the following cycle.
- Back-to-back throughput: one transaction per (downstream latency + 1) cycles.
- Write-only dmem requests: dmem_resp still pulses; dmem_rdata equals mem_rdata, which is don't-care.
- mem_resp while IDLE (stale response after reset mid-transaction): ignored; no requester resp.
- Reset mid-operation: open transaction and pending entries are dropped. Requesters are reset together with the arbiter.
- rdata outputs hold their last routed value when resp = 0.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous candidates, the requester not granted most recently wins.
  - The last-grant flop resets to imem, so the first tie goes to dmem.
- Undefined: fixed dmem priority as above; no last-grant flop.

Decomposition:
- rv32imc_types package gets:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D}.
  - mem_req_t struct {addr, rmask, wmask, wdata}.
- Sub-module arb_req_buffer: one-entry capture/hold of mem_req_t with a valid bit, load and clear inputs. Instantiated twice (imem, dmem).

Test Plan:
- Single imem read, addr 0x0000_1000, mem_resp after 3 cycles with rdata 0xDEAD_BEEF:
  - mem_rmask = 0xF in the request cycle.
  - imem_resp = 1 with imem_rdata 0xDEAD_BEEF exactly in the mem_resp cycle.
- Simultaneous imem read 0x100 and dmem write 0x200 (wmask 0x3, wdata 0x1234), fixed priority:
  - dmem write issued first.
  - imem read issued the cycle after dmem_resp.
  - Each resp goes only to its owner.
- With ARB_ROUND_ROBIN_EN, two consecutive simultaneous pairs: grant order dmem, imem, imem, dmem.
- dmem request arrives while BUSY_I:
  - Captured into pending.
  - Issued with the same addr/wdata one cycle after imem_resp; mem_wmask is a single-cycle pulse.
- rst asserted while BUSY_D, then mem_resp pulses 2 cycles later: both requester resps stay 0; state IDLE; next imem request is granted immediately.
- Back-to-back dmem reads 0x10, 0x14 with 1-cycle downstream latency: requests spaced 2 cycles apart; rdata delivered in order.
